tiny8_control_mc: RTL and testbench

Multicycle control unit for the tiny8 core with parameterised opcode width, multi-word operand fetch, and memory-wait handling. It sequences fetch, decode, operand fetch, execute and memory phases, and drives the datapath load enables and mux selects. A wait-state watchdog can be compiled in. Illegal opcodes and halts are reported as sticky states.

---
 rtl/tiny8_control_mc.sv | 203 ++++++++++++++++++++
 tb/tb_tiny8_control_mc.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny8_control_mc.sv
// tiny8 multicycle control: fetch/decode/opfetch/execute/memory sequencing.
// Ports: clk, rst (async high), opcode, acc_zero, mem_resp -> datapath
// enables, mux selects, opnd_idx, mem_read/mem_write, halted, fault,
// fault_code. Optional wait watchdog: define TINY8_CTRL_WATCHDOG_EN.
module tiny8_control_mc #(
  parameter int OPW = 4,
  parameter int IMM_WORDS = 1,
  parameter int MEM_TIMEOUT = 15,
  localparam int IW = (IMM_WORDS > 1) ? $clog2(IMM_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [OPW-1:0] opcode,
  input  logic          acc_zero,
  input  logic          mem_resp,
  output logic          load_pc,
  output logic          load_acc,
  output logic          load_rs,
  output logic          load_rd,
  output logic          load_ir,
  output logic          load_opnd,
  output logic          pcmux_sel,
  output logic          alumux1_sel,
  output logic          alumux2_sel,
  output logic [1:0]    addrmux_sel,
  output logic [IW-1:0] opnd_idx,
  output logic          mem_read,
  output logic          mem_write,
  output logic          halted,
  output logic          fault,
  output logic [1:0]    fault_code
);

  if (OPW < 4 || IMM_WORDS < 1 || MEM_TIMEOUT < 1) begin : g_param_chk
    $error("tiny8_control_mc: illegal parameter value");
  end

  localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
  localparam logic [OPW-1:0] OP_ALUR  = OPW'(1);
  localparam logic [OPW-1:0] OP_ALUI  = OPW'(2);
  localparam logic [OPW-1:0] OP_LOAD  = OPW'(3);
  localparam logic [OPW-1:0] OP_STORE = OPW'(4);
  localparam logic [OPW-1:0] OP_JMP   = OPW'(5);
  localparam logic [OPW-1:0] OP_BRZ   = OPW'(6);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(7);
  localparam logic [OPW-1:0] OP_MOVRD = OPW'(8);
  localparam logic [IW-1:0]  LAST_W   = IW'(IMM_WORDS - 1);

  typedef enum logic [2:0] {
    S_FETCH1,
    S_FETCH2,
    S_DECODE,
    S_OPFETCH,
    S_EXECUTE,
    S_MEMORY,
    S_HALT,
    S_FAULT
  } state_t;

  state_t state, state_n;
  logic [IW-1:0] ocnt, ocnt_n;
  logic [1:0] fcode, fcode_n;
  logic is_imm, is_ill, tmo;

  assign is_imm = (opcode >= OP_ALUI) && (opcode <= OP_BRZ);
  assign is_ill = opcode > OP_MOVRD;

`ifdef TINY8_CTRL_WATCHDOG_EN
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  logic [WCW-1:0] wcnt;
  logic wait_st;

  assign wait_st = (state == S_FETCH2) || (state == S_OPFETCH) ||
                   (state == S_MEMORY);
  // a response in the limit cycle wins over the timeout
  assign tmo = wait_st && !mem_resp && (wcnt == WCW'(MEM_TIMEOUT));

  // counts silent cycles of the access in flight; each completed
  // access restarts it so multi-word operand fetch is timed per word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (state_n != state || mem_resp) begin
      wcnt <= '0;
    end else if (wait_st) begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  // no watchdog: memory waits are unbounded
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH1;
      ocnt  <= '0;
      fcode <= 2'b00;
    end else begin
      state <= state_n;
      ocnt  <= ocnt_n;
      fcode <= fcode_n;
    end
  end

  always_comb begin
    state_n     = state;
    ocnt_n      = ocnt;
    fcode_n     = fcode;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    load_rs     = 1'b0;
    load_rd     = 1'b0;
    load_ir     = 1'b0;
    load_opnd   = 1'b0;
    pcmux_sel   = 1'b0;
    alumux1_sel = 1'b0;
    alumux2_sel = 1'b0;
    addrmux_sel = 2'b00;
    opnd_idx    = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    fault_code  = 2'b00;
    unique case (state)
      S_FETCH1: state_n = S_FETCH2;
      S_FETCH2: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          load_ir = 1'b1;
          load_pc = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        load_rs = 1'b1;
        if (is_ill) begin
          state_n = S_FAULT;
          fcode_n = 2'b10;
        end else if (is_imm) begin
          state_n = S_OPFETCH;
          ocnt_n  = '0;
        end else begin
          state_n = S_EXECUTE;
        end
      end
      S_OPFETCH: begin
        mem_read = 1'b1;
        opnd_idx = ocnt;
        if (mem_resp) begin
          load_opnd = 1'b1;
          load_pc   = 1'b1;
          ocnt_n    = ocnt + 1'b1;
          if (ocnt == LAST_W) state_n = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_n = S_FETCH1;
        case (opcode)
          OP_ALUR: load_acc = 1'b1;
          OP_ALUI: begin
            load_acc    = 1'b1;
            alumux2_sel = 1'b1;
          end
          OP_MOVRD: load_rd = 1'b1;
          OP_JMP: begin
            load_pc   = 1'b1;
            pcmux_sel = 1'b1;
          end
          OP_BRZ: begin
            load_pc   = acc_zero;
            pcmux_sel = acc_zero;
          end
          OP_LOAD, OP_STORE: state_n = S_MEMORY;
          OP_HALT: state_n = S_HALT;
          OP_NOP: state_n = S_FETCH1;
          default: state_n = S_FETCH1;
        endcase
      end
      S_MEMORY: begin
        addrmux_sel = 2'b01;
        mem_read    = (opcode == OP_LOAD);
        mem_write   = (opcode != OP_LOAD);
        if (mem_resp) begin
          load_acc    = (opcode == OP_LOAD);
          alumux1_sel = (opcode == OP_LOAD);
          state_n     = S_FETCH1;
        end
      end
      S_HALT: halted = 1'b1;
      S_FAULT: begin
        fault      = 1'b1;
        fault_code = fcode;
      end
    endcase
    if (tmo) begin
      state_n = S_FAULT;
      fcode_n = 2'b01;
    end
  end

endmodule

// File: tb/tb_tiny8_control_mc.sv
// Randomized self-checking bench for tiny8_control_mc.
// Memory responder with per-access wait counts; instruction-level model.
module tb_tiny8_control_mc;

  localparam int IMMW = 2;
  localparam int TMO  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = '0;
  logic       acc_zero = 1'b0;
  logic       mem_resp = 1'b0;
  logic       load_pc, load_acc, load_rs, load_rd, load_ir, load_opnd;
  logic       pcmux_sel, alumux1_sel, alumux2_sel;
  logic [1:0] addrmux_sel;
  logic       opnd_idx;
  logic       mem_read, mem_write, halted, fault;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;
  int wq[$];
  int wc = 0;

  always #5 clk = ~clk;

  tiny8_control_mc #(
    .OPW(4), .IMM_WORDS(IMMW), .MEM_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .acc_zero(acc_zero),
    .mem_resp(mem_resp), .load_pc(load_pc), .load_acc(load_acc),
    .load_rs(load_rs), .load_rd(load_rd), .load_ir(load_ir),
    .load_opnd(load_opnd), .pcmux_sel(pcmux_sel),
    .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
    .addrmux_sel(addrmux_sel), .opnd_idx(opnd_idx),
    .mem_read(mem_read), .mem_write(mem_write), .halted(halted),
    .fault(fault), .fault_code(fault_code)
  );

  wire [17:0] all_out = {load_pc, load_acc, load_rs, load_rd, load_ir,
    load_opnd, pcmux_sel, alumux1_sel, alumux2_sel, addrmux_sel,
    opnd_idx, mem_read, mem_write, halted, fault, fault_code};

  // Memory: answers the head-of-queue access after that many wait
  // cycles; outside requests mem_resp is random noise.
  task automatic respond();
    if (mem_read || mem_write) begin
      if (wq.size() != 0 && wc == wq[0]) begin
        mem_resp = 1'b1;
        void'(wq.pop_front());
        wc = 0;
      end else begin
        mem_resp = 1'b0;
        wc++;
      end
    end else begin
      mem_resp = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_resp = 1'b0;
    wq.delete();
    wc = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (all_out !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 0", all_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  // One instruction from FETCH1 to the next FETCH1; fixw<0 = random waits.
  task automatic run_instr(input int op, input bit az, input int fixw);
    bit imm, ls, jmp;
    int na, ws, w0, wl, ncyc, irpos, nopnd;
    int act[11];
    int exp[11];
    string nm[11];
    imm = (op >= 2 && op <= 6);
    ls  = (op == 3 || op == 4);
    jmp = (op == 5) || (op == 6 && az);
    na  = 1 + (imm ? IMMW : 0) + (ls ? 1 : 0);
    wq.delete();
    wc = 0;
    ws = 0;
    w0 = 0;
    wl = 0;
    for (int i = 0; i < na; i++) begin
      int w;
      w = (fixw >= 0) ? fixw : int'($urandom_range(0, 2));
      wq.push_back(w);
      ws += w;
      if (i == 0) w0 = w;
      wl = w;
    end
    ncyc = 4 + (imm ? IMMW : 0) + (ls ? 1 : 0) + ws;
    foreach (act[i]) act[i] = 0;
    irpos = -1;
    nopnd = 0;
    opcode = 4'(op);
    acc_zero = az;
    for (int c = 0; c < ncyc; c++) begin
      respond();
      #1;
      checks++;
      if ((mem_read && mem_write) || addrmux_sel[1] || halted || fault) begin
        errors++;
        $display("FAIL bus op=%0d cyc=%0d rd=%b wr=%b amux=%b h=%b f=%b expected no rd&wr, amux!=1x, h=0, f=0",
                 op, c, mem_read, mem_write, addrmux_sel, halted, fault);
      end
      if (load_ir) begin
        act[0]++;
        irpos = c;
      end
      act[1]  += int'(load_rs);
      act[2]  += int'(load_pc);
      act[3]  += int'(load_pc && pcmux_sel);
      act[4]  += int'(load_acc);
      act[5]  += int'(load_acc && alumux1_sel);
      act[6]  += int'(load_acc && alumux2_sel);
      act[7]  += int'(load_rd);
      act[8]  += int'(mem_write);
      act[9]  += int'(addrmux_sel == 2'b01);
      act[10] += int'(mem_read || mem_write);
      if (load_opnd) begin
        checks++;
        if (opnd_idx !== nopnd[0]) begin
          errors++;
          $display("FAIL opnd_idx op=%0d got %0d expected %0d",
                   op, opnd_idx, nopnd);
        end
        nopnd++;
      end
      @(negedge clk);
    end
    nm = '{"load_ir", "load_rs", "load_pc", "jump", "load_acc",
           "acc_from_mem", "acc_imm", "load_rd", "write_cycles",
           "operand_addr", "req_cycles"};
    exp = '{1, 1, 1 + (imm ? IMMW : 0) + int'(jmp), int'(jmp),
            int'(op == 1 || op == 2 || op == 3), int'(op == 3),
            int'(op == 2), int'(op == 8), (op == 4) ? wl + 1 : 0,
            ls ? wl + 1 : 0, ws + na};
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (act[i] != exp[i]) begin
        errors++;
        $display("FAIL %s op=%0d got %0d expected %0d",
                 nm[i], op, act[i], exp[i]);
      end
    end
    checks++;
    if (irpos != 1 + w0 || nopnd != (imm ? IMMW : 0)) begin
      errors++;
      $display("FAIL ir_timing op=%0d irpos=%0d opnd=%0d expected %0d %0d",
               op, irpos, nopnd, 1 + w0, imm ? IMMW : 0);
    end
  endtask

  task automatic test_nop();
    run_instr(0, 1'b0, 0);
    run_instr(0, 1'b1, 0);
  endtask

  task automatic test_alu_imm();
    run_instr(2, 1'b0, 1);
  endtask

  task automatic test_brz();
    run_instr(6, 1'b0, -1);
    run_instr(6, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    int ops[8] = '{0, 1, 2, 3, 4, 5, 6, 8};
    for (int n = 0; n < 40; n++) begin
      run_instr(ops[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), -1);
    end
  endtask

  task automatic test_rst_wait();
    wq.delete();
    wc = 0;
    opcode = 4'd0;
    mem_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL fetch_wait rd got %b expected 1", mem_read);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (all_out !== 18'd0) begin
      errors++;
      $display("FAIL rst_in_wait got %b expected 0", all_out);
    end
    @(negedge clk);
    rst = 1'b0;
    run_instr(0, 1'b0, -1);
  endtask

  task automatic test_halt();
    int w0, hpos;
    logic exp_h;
    wq.delete();
    wc = 0;
    w0 = $urandom_range(0, 2);
    wq.push_back(w0);
    opcode = 4'd7;
    hpos = 4 + w0;
    for (int c = 0; c < hpos + 6; c++) begin
      respond();
      #1;
      exp_h = (c >= hpos);
      checks++;
      if (halted !== exp_h || (exp_h && (mem_read || mem_write || load_pc))) begin
        errors++;
        $display("FAIL halt cyc=%0d h=%b rd=%b wr=%b expected h=%b idle",
                 c, halted, mem_read, mem_write, exp_h);
      end
      @(negedge clk);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset got %b expected 0", halted);
    end
    @(negedge clk);
    rst = 1'b0;
    run_instr(1, 1'b0, -1);
  endtask

  task automatic test_illegal(input int op);
    int w0, fpos;
    logic exp_f;
    logic [1:0] exp_c;
    wq.delete();
    wc = 0;
    w0 = $urandom_range(0, 2);
    wq.push_back(w0);
    opcode = 4'(op);
    fpos = 3 + w0;
    for (int c = 0; c < fpos + 20; c++) begin
      respond();
      #1;
      exp_f = (c >= fpos);
      exp_c = exp_f ? 2'b10 : 2'b00;
      checks++;
      if (fault !== exp_f || fault_code !== exp_c) begin
        errors++;
        $display("FAIL illegal op=%0d cyc=%0d f=%b code=%b expected %b %b",
                 op, c, fault, fault_code, exp_f, exp_c);
      end
      @(negedge clk);
    end
    do_reset();
  endtask

`ifdef TINY8_CTRL_WATCHDOG_EN
  task automatic test_timeout();
    int fpos;
    logic exp_f, exp_w;
    wq.delete();
    wc = 0;
    wq = '{0, 0, 0};
    opcode = 4'd4;
    fpos = 6 + TMO + 1;
    for (int c = 0; c < fpos + 4; c++) begin
      respond();
      #1;
      exp_f = (c >= fpos);
      exp_w = (c >= 6 && c < fpos);
      checks++;
      if (fault !== exp_f || mem_write !== exp_w ||
          fault_code !== (exp_f ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL timeout cyc=%0d f=%b wr=%b code=%b expected f=%b wr=%b",
                 c, fault, mem_write, fault_code, exp_f, exp_w);
      end
      @(negedge clk);
    end
    do_reset();
    run_instr(4, 1'b0, TMO);
    run_instr(3, 1'b0, TMO);
  endtask
`else
  task automatic test_long_wait();
    run_instr(3, 1'b0, 20);
    run_instr(4, 1'b1, 12);
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nop();
    test_alu_imm();
    test_brz();
    test_back_to_back();
    test_rst_wait();
    test_halt();
    test_illegal(12);
    test_illegal($urandom_range(9, 15));
`ifdef TINY8_CTRL_WATCHDOG_EN
    test_timeout();
`else
    test_long_wait();
`endif
    run_instr(0, 1'b0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
